// File: rtl/speed_meas_pkg.sv
// Shared types and defaults for the two-gate speed measurement controller.
package speed_meas_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      TIMING    = 3'd1,
      DIV_START = 3'd2,
      DIVIDE    = 3'd3,
      SHOW      = 3'd4
   } state_t;

   localparam int          SPEED_W         = 7;
   localparam int unsigned DEF_NUMERATOR   = 360_000_000;
   localparam int unsigned DEF_TIMEOUT_CYC = 12_000_000;

endpackage

// File: rtl/speed_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses NUM_W cycles after an accepted start.
module speed_divider #(
   parameter int NUM_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [NUM_W-1:0] dividend,
   input  logic [NUM_W-1:0] divisor,
   output logic [NUM_W-1:0] quotient,
   output logic             done
);

   localparam int CW = $clog2(NUM_W + 1);

   logic [NUM_W-1:0] rem;
   logic [NUM_W-1:0] dvsr;
   logic [CW-1:0]    steps;
   logic             run;
   logic [NUM_W:0]   shifted;
   logic [NUM_W:0]   diff;

   // quotient doubles as the dividend shift register; its MSB feeds the partial remainder
   assign shifted = {rem, quotient[NUM_W-1]};
   assign diff    = shifted - {1'b0, dvsr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         dvsr     <= '0;
         quotient <= '0;
         steps    <= '0;
         run      <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            run   <= 1'b0;
            steps <= '0;
         end else if (!run) begin
            if (start) begin
               quotient <= dividend;
               dvsr     <= divisor;
               rem      <= '0;
               steps    <= CW'(NUM_W);
               run      <= 1'b1;
            end
         end else begin
            if (!diff[NUM_W]) begin
               rem      <= diff[NUM_W-1:0];
               quotient <= {quotient[NUM_W-2:0], 1'b1};
            end else begin
               rem      <= shifted[NUM_W-1:0];
               quotient <= {quotient[NUM_W-2:0], 1'b0};
            end
            steps <= steps - CW'(1);
            if (steps == CW'(1)) begin
               run  <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/speed_meas_ctrl.sv
// Two-gate transit timer with sequenced divide and saturated speed output.
// Optional SENSOR_SYNC_EN adds a 2-FF synchronizer on both sensor inputs.
module speed_meas_ctrl
   import speed_meas_pkg::*;
#(
   parameter int unsigned NUMERATOR   = DEF_NUMERATOR,
   parameter int          NUM_W       = 32,
   parameter int          CNT_W       = 24,
   parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int unsigned SPEED_MAX   = 99
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sensor_a,
   input  logic               sensor_b,
   input  logic               clear,
   output logic [SPEED_W-1:0] speed,
   output logic               speed_valid,
   output logic               busy,
   output logic               timeout_err
);

   logic             a_s, b_s, a_last, b_last, a_rise, b_rise;
   state_t           state;
   logic [CNT_W-1:0] count, transit;
   logic             zero_div;
   logic             div_start, div_done, wait_done;
   logic [NUM_W-1:0] quotient;
   logic [SPEED_W-1:0] speed_next;

`ifdef SENSOR_SYNC_EN
   logic [1:0] a_sync, b_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sync <= '0;
         b_sync <= '0;
      end else begin
         a_sync <= {a_sync[0], sensor_a};
         b_sync <= {b_sync[0], sensor_b};
      end
   end

   assign a_s = a_sync[1];
   assign b_s = b_sync[1];
`else
   assign a_s = sensor_a;
   assign b_s = sensor_b;
`endif

   assign a_rise = a_s & ~a_last;
   assign b_rise = b_s & ~b_last;
   assign busy   = (state == TIMING) || (state == DIVIDE);

   // zero transit skips the divider but count paces DIVIDE so latency matches a real divide
   assign div_start = (state == DIV_START) && (transit != '0);
   assign wait_done = zero_div ? (count == CNT_W'(NUM_W)) : div_done;
   assign speed_next = (zero_div || (quotient > NUM_W'(SPEED_MAX))) ? SPEED_W'(SPEED_MAX)
                                                                     : quotient[SPEED_W-1:0];

   speed_divider #(.NUM_W(NUM_W)) u_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (div_start),
      .abort    (clear),
      .dividend (NUM_W'(NUMERATOR)),
      .divisor  (NUM_W'(transit)),
      .quotient (quotient),
      .done     (div_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         transit     <= '0;
         zero_div    <= 1'b0;
         a_last      <= 1'b0;
         b_last      <= 1'b0;
         speed       <= '0;
         speed_valid <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         a_last      <= a_s;
         b_last      <= b_s;
         speed_valid <= 1'b0;
         if (clear) begin
            state       <= IDLE;
            count       <= '0;
            zero_div    <= 1'b0;
            speed       <= '0;
            timeout_err <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (a_rise) begin
                     state       <= TIMING;
                     count       <= '0;
                     timeout_err <= 1'b0;
                  end
               end
               TIMING: begin
                  if (a_rise) begin
                     count <= '0;
                  end else if (b_rise) begin
                     transit <= count;
                     state   <= DIV_START;
                  end else if (count == CNT_W'(TIMEOUT_CYC - 1)) begin
                     state       <= IDLE;
                     timeout_err <= 1'b1;
                  end else begin
                     count <= count + CNT_W'(1);
                  end
               end
               DIV_START: begin
                  zero_div <= (transit == '0);
                  count    <= '0;
                  state    <= DIVIDE;
               end
               DIVIDE: begin
                  if (zero_div) count <= count + CNT_W'(1);
                  if (wait_done) begin
                     speed       <= speed_next;
                     speed_valid <= 1'b1;
                     state       <= SHOW;
                  end
               end
               SHOW:    state <= IDLE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_speed_meas_ctrl.sv
// Self-checking bench: latency-based reference model compared every cycle, plus directed literal checks.
module tb_speed_meas_ctrl;

   localparam int N    = 1000;
   localparam int TO   = 200;
   localparam int NW   = 32;
   localparam int LAT  = NW + 2;
   localparam int SMAX = 99;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sensor_a = 1'b0;
   logic       sensor_b = 1'b0;
   logic       clear = 1'b0;
   logic [6:0] speed;
   logic       speed_valid, busy, timeout_err;

   speed_meas_ctrl #(
      .NUMERATOR   (N),
      .NUM_W       (NW),
      .CNT_W       (24),
      .TIMEOUT_CYC (TO),
      .SPEED_MAX   (SMAX)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sensor_a    (sensor_a),
      .sensor_b    (sensor_b),
      .clear       (clear),
      .speed       (speed),
      .speed_valid (speed_valid),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // model: 0 idle, 1 timing, 2 result pending (fixed latency from the stop edge)
   int n_edge = 0;
   int m_mode = 0, m_cnt = 0, m_tr = 0, m_tb = 0, m_speed = 0;
   bit m_valid = 0, m_err = 0, m_busy = 0, pa = 0, pb = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s @edge %0d: got %0d, want %0d", name, n_edge, act, exp);
      end
   endtask

   function automatic int quot(input int t);
      if (t == 0) return SMAX;
      return (N / t > SMAX) ? SMAX : N / t;
   endfunction

   always @(posedge clk) begin : model
      bit a, b, c, ar, br;
      a = sensor_a; b = sensor_b; c = clear;
      #1;
      n_edge++;
      if (!rst_n) begin
         m_mode = 0; m_speed = 0; m_err = 0; m_valid = 0; m_busy = 0; pa = 0; pb = 0;
      end else begin
         ar = a && !pa;
         br = b && !pb;
         pa = a; pb = b;
         m_valid = 0;
         if (c) begin
            m_mode = 0; m_speed = 0; m_err = 0;
         end else begin
            case (m_mode)
               0: if (ar) begin m_mode = 1; m_cnt = 0; m_err = 0; end
               1: begin
                  if (ar) m_cnt = 0;
                  else if (br) begin m_tr = m_cnt; m_tb = n_edge; m_mode = 2; end
                  else if (m_cnt == TO - 1) begin m_mode = 0; m_err = 1; end
                  else m_cnt++;
               end
               default: begin
                  if (n_edge == m_tb + LAT) begin m_speed = quot(m_tr); m_valid = 1; end
                  else if (n_edge == m_tb + LAT + 1) m_mode = 0;
               end
            endcase
         end
         m_busy = (m_mode == 1) || (m_mode == 2 && n_edge > m_tb && n_edge < m_tb + LAT);
         chk("speed", int'(speed), m_speed);
         chk("speed_valid", int'(speed_valid), int'(m_valid));
         chk("busy", int'(busy), int'(m_busy));
         chk("timeout_err", int'(timeout_err), int'(m_err));
      end
   end

   task automatic cyc(input int k);
      repeat (k) @(negedge clk);
   endtask

   // a rises, b rises gap edges later: transit = gap-1
   task automatic start_meas(input int gap, output int b_edge);
      sensor_a = 1'b1;
      cyc(gap);
      sensor_b = 1'b1;
      b_edge = n_edge + 1;
      cyc(1);
      sensor_a = 1'b0;
      sensor_b = 1'b0;
   endtask

   task automatic wait_valid(input int b_edge, input int exp, input string nm);
      for (int i = 0; i < LAT + 5; i++) begin
         @(negedge clk);
         if (speed_valid) break;
      end
      chk({nm, " speed"}, int'(speed), exp);
      chk({nm, " latency"}, n_edge - b_edge, LAT);
      chk({nm, " model"}, m_speed, exp);
      cyc(3);
   endtask

   initial begin
      int be, pulses;
      cyc(3);
      chk("rst speed", int'(speed), 0);
      chk("rst valid", int'(speed_valid), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst err", int'(timeout_err), 0);
      rst_n = 1'b1;
      cyc(3);

      start_meas(6, be);  wait_valid(be, 99, "sat");
      start_meas(1, be);  wait_valid(be, 99, "zero");
      start_meas(21, be); wait_valid(be, 50, "basic");

      // timeout keeps previous speed, next start clears the error
      sensor_a = 1'b1; cyc(1); sensor_a = 1'b0;
      cyc(205);
      chk("to err", int'(timeout_err), 1);
      chk("to speed", int'(speed), 50);
      chk("to busy", int'(busy), 0);
      chk("to model", int'(m_err), 1);
      sensor_a = 1'b1; cyc(1);
      chk("to clr", int'(timeout_err), 0);
      sensor_a = 1'b0; cyc(9);
      sensor_a = 1'b1; cyc(1);
      sensor_a = 1'b0; cyc(20);
      sensor_b = 1'b1; be = n_edge + 1; cyc(1); sensor_b = 1'b0;
      wait_valid(be, 50, "restart");

      // sensor activity during divide is ignored
      start_meas(41, be);
      cyc(5);  sensor_b = 1'b1; sensor_a = 1'b1;
      cyc(3);  sensor_b = 1'b0; sensor_a = 1'b0;
      cyc(2);  sensor_b = 1'b1;
      cyc(2);  sensor_b = 1'b0;
      wait_valid(be, 25, "div_ign");

      // async reset mid-divide
      start_meas(21, be);
      cyc(15);
      rst_n = 1'b0;
      #2;
      chk("mrst speed", int'(speed), 0);
      chk("mrst busy", int'(busy), 0);
      chk("mrst valid", int'(speed_valid), 0);
      cyc(2);
      rst_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (speed_valid) pulses++;
      end
      chk("mrst no valid", pulses, 0);

      // clear mid-divide aborts
      start_meas(21, be);
      cyc(5); clear = 1'b1; cyc(1); clear = 1'b0;
      chk("clr speed", int'(speed), 0);
      chk("clr busy", int'(busy), 0);
      cyc(40);

      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 15) == 0) sensor_a = ~sensor_a;
         if ($urandom_range(0, 19) == 0) sensor_b = ~sensor_b;
         clear = ($urandom_range(0, 299) == 0);
      end
      clear = 1'b0;
      cyc(50);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
